// File: rtl/latch_sr.sv
// latch_sr: per-bit clocked set/reset flag register with optional request
// synchronizers, complementary outputs and one-cycle change-of-state pulses.
module latch_sr #(
  parameter int               WIDTH        = 1,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               SET_DOMINANT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  logic [WIDTH-1:0] ss;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] flag_d;
  logic [WIDTH-1:0] flag_q;
  logic [WIDTH-1:0] prev_q;

  // Both-active resolution is a build-time choice, so no indeterminate state exists.
  function automatic logic [WIDTH-1:0] sr_next(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] set_req,
                                               input logic [WIDTH-1:0] clr_req);
    if (SET_DOMINANT != 0) begin
      return (cur & ~clr_req) | set_req;
    end
    return (cur | set_req) & ~clr_req;
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ss = s;
      assign rs = r;
    end else begin : g_sync
      logic [WIDTH-1:0] s_sync_q [SYNC_STAGES];
      logic [WIDTH-1:0] r_sync_q [SYNC_STAGES];

      // Stage p0..pN-1: s and r share one chain depth so their relative timing holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            s_sync_q[i] <= '0;
            r_sync_q[i] <= '0;
          end
        end else begin
          s_sync_q[0] <= s;
          r_sync_q[0] <= r;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            s_sync_q[i] <= s_sync_q[i-1];
            r_sync_q[i] <= r_sync_q[i-1];
          end
        end
      end

      assign ss = s_sync_q[SYNC_STAGES-1];
      assign rs = r_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    flag_d = sr_next(flag_q, ss, rs);
  end

  // Flag stage plus its one-edge-delayed copy for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= RESET_VALUE;
      prev_q <= RESET_VALUE;
    end else begin
      flag_q <= flag_d;
      prev_q <= flag_q;
    end
  end

  assign q      = flag_q;
  assign q_n    = ~flag_q;
  assign q_rise = flag_q & ~prev_q;
  assign q_fall = ~flag_q & prev_q;

endmodule

// File: tb/tb_latch_sr.sv
// Bench for latch_sr: four builds driven by shared requests, checked every cycle
// against a request-history reference model plus hand-computed expectations.
module tb_latch_sr;

  localparam int         SSV  [4] = '{2, 2, 0, 1};
  localparam int         SDV  [4] = '{0, 1, 0, 1};
  localparam logic [3:0] RVV  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1011};
  localparam logic [3:0] MASK [4] = '{4'b0001, 4'b0001, 4'b1111, 4'b1111};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] s = '0;
  logic [3:0] r = '0;

  logic       qa, qna, ra, fa, qb, qnb, rb, fb;
  logic [3:0] qc, qnc, rc, fc, qd, qnd, rd, fd;
  logic [3:0] aq [4], aqn [4], ar [4], af [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  latch_sr #(.WIDTH(1), .SYNC_STAGES(2), .RESET_VALUE(1'b0), .SET_DOMINANT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(s[0]), .r(r[0]), .q(qa), .q_n(qna), .q_rise(ra), .q_fall(fa));
  latch_sr #(.WIDTH(1), .SYNC_STAGES(2), .RESET_VALUE(1'b0), .SET_DOMINANT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(s[0]), .r(r[0]), .q(qb), .q_n(qnb), .q_rise(rb), .q_fall(fb));
  latch_sr #(.WIDTH(4), .SYNC_STAGES(0), .RESET_VALUE(4'b0000), .SET_DOMINANT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(qc), .q_n(qnc), .q_rise(rc), .q_fall(fc));
  latch_sr #(.WIDTH(4), .SYNC_STAGES(1), .RESET_VALUE(4'b1011), .SET_DOMINANT(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(qd), .q_n(qnd), .q_rise(rd), .q_fall(fd));

  assign aq[0] = {3'b000, qa};  assign aqn[0] = {3'b000, qna};
  assign ar[0] = {3'b000, ra};  assign af[0]  = {3'b000, fa};
  assign aq[1] = {3'b000, qb};  assign aqn[1] = {3'b000, qnb};
  assign ar[1] = {3'b000, rb};  assign af[1]  = {3'b000, fb};
  assign aq[2] = qc;  assign aqn[2] = qnc;  assign ar[2] = rc;  assign af[2] = fc;
  assign aq[3] = qd;  assign aqn[3] = qnd;  assign ar[3] = rd;  assign af[3] = fd;

  // Reference model: history of sampled requests; each build looks SYNC_STAGES samples back.
  logic [7:0] hist [$];
  logic [3:0] mq [4];
  logic [3:0] mprev [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < 4; k++) begin
        mq[k]    <= RVV[k];
        mprev[k] <= RVV[k];
      end
    end else begin
      if (hist.size() >= 4) void'(hist.pop_front());
      hist.push_back({s, r});
      for (int k = 0; k < 4; k++) begin
        automatic int         idx = hist.size() - 1 - SSV[k];
        automatic logic [7:0] e   = 8'h00;
        automatic logic [3:0] nq  = mq[k];
        if (idx >= 0) e = hist[idx];
        for (int b = 0; b < 4; b++) begin
          if (e[4+b] && e[b])  nq[b] = (SDV[k] != 0);
          else if (e[4+b])     nq[b] = 1'b1;
          else if (e[b])       nq[b] = 1'b0;
        end
        mprev[k] <= mq[k];
        mq[k]    <= nq & MASK[k];
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model_q[%0d]", k),    aq[k],  mq[k]);
      chk($sformatf("model_qn[%0d]", k),   aqn[k], ~mq[k] & MASK[k]);
      chk($sformatf("model_rise[%0d]", k), ar[k],  mq[k] & ~mprev[k] & MASK[k]);
      chk($sformatf("model_fall[%0d]", k), af[k],  ~mq[k] & mprev[k] & MASK[k]);
    end
  end

  task automatic drive(input logic [3:0] sv, input logic [3:0] rv);
    @(negedge clk);
    s = sv;
    r = rv;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s = '0;
    r = '0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  logic [1:0] seq_sr [7] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
  logic       seq_q  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset held while clocking with a set request.
    s = 4'b0001;
    #1 rst_n = 1'b0;
    edges(3);
    chk("rst_q", {3'b0, qa}, 4'b0000);
    chk("rst_qn", {3'b0, qna}, 4'b0001);
    chk("rst_rise", {3'b0, ra}, 4'b0000);
    chk("rst_qd", qd, 4'b1011);
    chk("rst_qnd", qnd, 4'b0100);
    @(negedge clk);
    rst_n = 1'b1;
    edges(2);
    chk("release_q_edge2", {3'b0, qa}, 4'b0000);
    edges(1);
    chk("release_q_edge3", {3'b0, qa}, 4'b0001);
    chk("release_rise_edge3", {3'b0, ra}, 4'b0001);
    edges(1);
    chk("release_rise_edge4", {3'b0, ra}, 4'b0000);

    // Level request sequence, each step held 10 cycles.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      automatic logic [1:0] p = seq_sr[i];
      automatic logic prevq = (i == 0) ? 1'b0 : seq_q[i-1];
      drive({3'b0, p[1]}, {3'b0, p[0]});
      edges(2);
      chk($sformatf("seq%0d_before", i), {3'b0, qa}, {3'b0, prevq});
      edges(1);
      chk($sformatf("seq%0d_edge3", i), {3'b0, qa}, {3'b0, seq_q[i]});
      edges(7);
      chk($sformatf("seq%0d_end", i), {3'b0, qa}, {3'b0, seq_q[i]});
    end

    // Simultaneous requests: set-dominant from 0, reset-dominant from 1.
    drive(4'b0000, 4'b0001); edges(5);
    drive(4'b0001, 4'b0001); edges(5);
    chk("both_setdom_q", {3'b0, qb}, 4'b0001);
    chk("both_rstdom_q", {3'b0, qa}, 4'b0000);
    drive(4'b0001, 4'b0000); edges(5);
    chk("set_again_q", {3'b0, qa}, 4'b0001);
    drive(4'b0001, 4'b0001);
    edges(2);
    chk("rstdom_hold_q", {3'b0, qa}, 4'b0001);
    edges(1);
    chk("rstdom_clear_q", {3'b0, qa}, 4'b0000);
    chk("rstdom_fall", {3'b0, fa}, 4'b0001);
    edges(1);
    chk("rstdom_fall_once", {3'b0, fa}, 4'b0000);
    chk("setdom_keep_q", {3'b0, qb}, 4'b0001);

    // Asynchronous reset between edges with a set still in the synchronizer.
    drive(4'b0001, 4'b0000); edges(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_q", {3'b0, qa}, 4'b0000);
    chk("async_qn", {3'b0, qna}, 4'b0001);
    chk("async_rise", {3'b0, ra}, 4'b0000);
    chk("async_qd", qd, 4'b1011);
    s = '0;
    r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk("async_after_q", {3'b0, qa}, 4'b0000);
      chk("async_after_rise", {3'b0, ra}, 4'b0000);
    end

    // Unsynchronized 4-bit build and non-zero reset value.
    do_reset();
    edges(1);
    chk("rv_q", qd, 4'b1011);
    chk("rv_qn", qnd, 4'b0100);
    chk("rv_rise", rd, 4'b0000);
    chk("rv_fall", fd, 4'b0000);
    drive(4'b0101, 4'b0000); edges(1);
    chk("nosync_set", qc, 4'b0101);
    drive(4'b0000, 4'b0001); edges(1);
    chk("nosync_clr", qc, 4'b0100);
    chk("nosync_fall", fc, 4'b0001);
    drive(4'b0000, 4'b0000); edges(1);
    chk("nosync_fall_once", fc, 4'b0000);

    // Randomized held levels with occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      drive(4'($urandom), 4'($urandom & $urandom));
      repeat ($urandom_range(1, 4)) @(posedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    edges(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
